// File: rtl/clk_monitor.sv
`default_nettype none
// ============================================================================
// clk_monitor : counts synchronised tog_in transitions per fixed window and
//               tracks rate lock. Optional macro CLK_MONITOR_STICKY_FAULT_EN.
// Revision    : 1.0
// ============================================================================
module clk_monitor #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int EXP_MIN       = 180,
  parameter int EXP_MAX       = 220,
  parameter int LOCK_WINDOWS  = 4,
  localparam int CW           = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tog_in,
  output logic [CW-1:0] last_count,
  output logic          count_valid,
  output logic          locked,
  output logic          fault
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WW-1:0] c_WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [GW-1:0] c_LOCK_N   = GW'(LOCK_WINDOWS);
  localparam logic [CW-1:0] c_SAT      = '1;
  localparam logic [31:0]   c_MIN      = 32'(EXP_MIN);
  localparam logic [31:0]   c_MAX      = 32'(EXP_MAX);

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  logic          s1_q, s2_q, s3_q;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [CW-1:0] last_count_q, last_count_d;
  logic          count_valid_q, count_valid_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  state_e        state_q, state_d;
  logic          fault_q, fault_d;

  logic          w_trans;
  logic          w_win_last;
  logic [CW-1:0] w_edge_inc;
  logic          w_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      last_count_q  <= '0;
      count_valid_q <= 1'b0;
      good_cnt_q    <= '0;
      state_q       <= ACQUIRE;
      fault_q       <= 1'b0;
    end else begin
      s1_q          <= tog_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      win_cnt_q     <= win_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      last_count_q  <= last_count_d;
      count_valid_q <= count_valid_d;
      good_cnt_q    <= good_cnt_d;
      state_q       <= state_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    w_trans    = s2_q ^ s3_q;
    w_win_last = (win_cnt_q == c_WIN_LAST);
    // A transition on the closing cycle still belongs to the closing window.
    w_edge_inc = (w_trans && (edge_cnt_q != c_SAT)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    w_good     = (32'(w_edge_inc) >= c_MIN) && (32'(w_edge_inc) <= c_MAX);

    win_cnt_d     = w_win_last ? '0 : win_cnt_q + 1'b1;
    edge_cnt_d    = w_win_last ? '0 : w_edge_inc;
    last_count_d  = w_win_last ? w_edge_inc : last_count_q;
    count_valid_d = w_win_last;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    if (w_win_last) begin
      if (state_q == ACQUIRE) begin
        if (w_good) begin
          good_cnt_d = good_cnt_q + 1'b1;
          if (good_cnt_d == c_LOCK_N) begin
            state_d = LOCKED;
          end
        end else begin
          good_cnt_d = '0;
        end
      end else begin
        if (!w_good) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
    end

`ifdef CLK_MONITOR_STICKY_FAULT_EN
    fault_d = fault_q | (w_win_last & ~w_good);
`else
    fault_d = w_win_last & ~w_good;
`endif
  end

  assign last_count  = last_count_q;
  assign count_valid = count_valid_q;
  assign locked      = (state_q == LOCKED);
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_monitor.sv
`default_nettype none
// ============================================================================
// tb_clk_monitor : drives tog_in patterns and compares every cycle against a
//                  window-count reference built from the sampled input history.
// Revision       : 1.0
// ============================================================================
module tb_clk_monitor;

  localparam int W     = 100;
  localparam int MINC  = 18;
  localparam int MAXC  = 22;
  localparam int LOCKW = 3;
  localparam int CW    = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tog_in = 1'b0;
  logic [CW-1:0] last_count;
  logic          count_valid;
  logic          locked;
  logic          fault;

  clk_monitor #(
    .WINDOW_CYCLES(W),
    .EXP_MIN      (MINC),
    .EXP_MAX      (MAXC),
    .LOCK_WINDOWS (LOCKW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tog_in     (tog_in),
    .last_count (last_count),
    .count_valid(count_valid),
    .locked     (locked),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: tog_in value sampled at each rising edge since release.
  bit samp[$];
  bit cur = 1'b0;
  int run_len = 0;
  bit any_bad = 1'b0;
  int exp_last = 0;
  bit exp_valid = 1'b0;
  bit exp_lock = 1'b0;
  bit exp_fault = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit tv(int j);
    return (j < 0) ? 1'b0 : samp[j];
  endfunction

  // A change in the input between edges j-1 and j is seen by the
  // counter during cycle j+2 after the two-flop synchroniser.
  function automatic int window_count(int last_idx);
    int c = 0;
    for (int k = last_idx - W + 1; k <= last_idx; k++)
      if (tv(k - 2) != tv(k - 3)) c++;
    return c;
  endfunction

  task automatic step(bit v);
    int  idx;
    int  c;
    bit  good;
    @(negedge clk);
    rst    = 1'b0;
    tog_in = v;
    samp.push_back(v);
    @(posedge clk);
    #1;
    idx       = samp.size() - 1;
    exp_valid = ((idx % W) == W - 1);
    good      = 1'b1;
    if (exp_valid) begin
      c        = window_count(idx);
      exp_last = c;
      good     = (c >= MINC) && (c <= MAXC);
      run_len  = good ? run_len + 1 : 0;
      exp_lock = (run_len >= LOCKW);
      if (!good) any_bad = 1'b1;
    end
`ifdef CLK_MONITOR_STICKY_FAULT_EN
    exp_fault = any_bad;
`else
    exp_fault = exp_valid && !good;
`endif
    chk("count_valid", count_valid, exp_valid);
    chk("locked", locked, exp_lock);
    chk("fault", fault, exp_fault);
    chk("last_count", last_count, exp_last);
  endtask

  task automatic do_reset(int nedges, bit lvl);
    @(negedge clk);
    rst    = 1'b1;
    tog_in = lvl;
    cur    = lvl;
    repeat (nedges) @(posedge clk);
    #1;
    chk("rst_count_valid", count_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    chk("rst_last_count", last_count, 0);
    samp.delete();
    run_len   = 0;
    any_bad   = 1'b0;
    exp_last  = 0;
    exp_valid = 1'b0;
    exp_lock  = 1'b0;
    exp_fault = 1'b0;
  endtask

  task automatic run_period(int ncyc, int per);
    for (int i = 0; i < ncyc; i++) begin
      if ((i % per) == 0) cur = ~cur;
      step(cur);
    end
  endtask

  task automatic run_hold(int ncyc);
    for (int i = 0; i < ncyc; i++) step(cur);
  endtask

  task automatic run_rand(int ncyc);
    int gap = $urandom_range(6, 4);
    for (int i = 0; i < ncyc; i++) begin
      gap--;
      if (gap == 0) begin
        cur = ~cur;
        gap = $urandom_range(6, 4);
      end
      step(cur);
    end
  endtask

  initial begin
    // Nominal rate: three good windows of 20, lock on the third.
    do_reset(3, 1'b0);
    run_period(300, 5);
    chk("lock_at_300", locked, 1);
    chk("count_20", last_count, 20);

    // Input stalls for a window: count 0, lock drops.
    run_hold(100);
    chk("stall_count", last_count, 0);
    chk("stall_unlock", locked, 0);

    // Too fast: 25 per window, never locks.
    run_period(200, 4);
    chk("fast_count", last_count, 25);
    chk("fast_nolock", locked, 0);

    // Good, bad, good, good, good: lock only at the fifth window.
    do_reset(1, 1'b0);
    run_period(100, 5);
    run_hold(100);
    run_period(200, 5);
    chk("gbggg_4th", locked, 0);
    run_period(100, 5);
    chk("gbggg_5th", locked, 1);

    // Transition landing on the last cycle of a window.
    while ((samp.size() % W) != W - 2) step(cur);
    for (int i = 0; i < 102; i++) begin
      int o;
      o = i - 2;
      if (o == -2 || (o >= 3 && o <= 93 && ((o - 3) % 5) == 0) || o == 97) cur = ~cur;
      step(cur);
    end
    chk("edge_at_last", last_count, 21);
    run_hold(100);
    chk("next_window_zero", last_count, 0);

    // Reset in mid-window while locked, then a fresh three-window relock.
    run_period(300, 5);
    chk("pre_rst_lock", locked, 1);
    run_period(50, 5);
    do_reset(1, cur);
    run_period(200, 5);
    chk("relock_wait", locked, 0);
    run_period(100, 5);
    chk("relock", locked, 1);

    // Input high through reset release counts as one transition.
    do_reset(2, 1'b1);
    run_hold(100);
    chk("high_at_release", last_count, 1);

    // Jittered rate around nominal.
    run_rand(1500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1000: measurement window length in clk cycles, at least 2.
REQ-002 SHALL have parameter EXP_MIN, default 180: minimum in-range transition count per window.
REQ-003 SHALL have parameter EXP_MAX, default 220: maximum in-range transition count per window, at least EXP_MIN.
REQ-004 SHALL have parameter LOCK_WINDOWS, default 4: consecutive good windows required to assert lock, at least 1.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port tog_in, input, 1 bit: asynchronous toggle from the monitored clock domain; toggle rate must be below clk/4.
REQ-008 SHALL have port last_count, output, CW bits: count from the last completed window, where CW = $clog2(WINDOW_CYCLES+1).
REQ-009 SHALL have port count_valid, output, 1 bit: one-cycle pulse when last_count updates.
REQ-010 SHALL have port locked, output, 1 bit: high while the monitored rate is in range.
REQ-011 SHALL have port fault, output, 1 bit: out-of-range indication (see Configuration).

Function
REQ-012 SHALL synchronise tog_in through two flops (s1, s2), then a third flop s3; transition = s2 XOR s3.
REQ-013 SHALL run window counter win_cnt 0..WINDOW_CYCLES-1, wrapping to 0 with no idle cycle between windows.
REQ-014 SHALL count transitions in a CW-bit edge counter that saturates at all-ones and never wraps.
REQ-015 SHALL include in the closing window a transition that occurs on the cycle win_cnt==WINDOW_CYCLES-1; the edge counter then restarts at 0.
REQ-016 SHALL register last_count and pulse count_valid on the cycle after win_cnt==WINDOW_CYCLES-1 (1-cycle latency).
REQ-017 SHALL define a window as good iff EXP_MIN <= count <= EXP_MAX, using an unsigned compare.
REQ-018 SHALL use FSM states ACQUIRE and LOCKED, with a good-window counter good_cnt.
REQ-019 In ACQUIRE, a good window SHALL increment good_cnt; at LOCK_WINDOWS the FSM SHALL enter LOCKED, and locked SHALL rise in the same cycle as that count_valid.
REQ-020 In ACQUIRE, a bad window SHALL clear good_cnt and keep the FSM in ACQUIRE.
REQ-021 In LOCKED, a bad window SHALL move the FSM to ACQUIRE with good_cnt=0, and locked SHALL fall in the same cycle as that count_valid.
REQ-022 In LOCKED, a good window SHALL keep the FSM in LOCKED.
REQ-023 With no tog_in activity, every window SHALL count 0 and be bad when EXP_MIN>0; locked SHALL never assert.

Reset
REQ-024 rst high SHALL clear s1, s2, s3, win_cnt, edge counter, good_cnt, last_count, count_valid, locked and fault, and SHALL set FSM=ACQUIRE.
REQ-025 The first window SHALL start on the first cycle with rst low.
REQ-026 If tog_in is high at reset release, the 0->1 seen at s2/s3 SHALL count as one transition.
REQ-027 rst asserted mid-window SHALL discard the partial count, emit no count_valid, and drop locked on the next edge.

Configuration
REQ-028 With macro CLK_MONITOR_STICKY_FAULT_EN defined, fault SHALL set on any bad window and stay high until rst.
REQ-029 Without that macro, fault SHALL be a one-cycle pulse coincident with count_valid for each bad window.
REQ-030 FSM and locked behaviour SHALL be identical with and without the macro.

Verification (WINDOW_CYCLES=100, EXP_MIN=18, EXP_MAX=22, LOCK_WINDOWS=3, tog_in starts low)
REQ-031 tog_in toggles every 5 clk cycles -> last_count=20 per window; count_valid at cycles 100, 200, 300 after reset release; locked rises at cycle 300; fault stays 0.
REQ-032 Locked, then tog_in held constant for one window -> last_count=0, locked falls with that count_valid, fault pulses once (or stays high if CLK_MONITOR_STICKY_FAULT_EN).
REQ-033 Toggle every 4 cycles (25 per window) -> every window bad, locked never rises, fault pulses each window without the macro.
REQ-034 Transition injected exactly at win_cnt=99 -> counted in the closing window (count 21, not 20), and the next window starts at 0.
REQ-035 rst pulsed for 1 cycle at win_cnt=50 while locked -> locked=0 on the next edge, no count_valid for the partial window, and relock requires 3 fresh good windows.
REQ-036 Good, bad, good, good, good window sequence -> good_cnt resets after the bad window, and locked rises only at the 5th count_valid.
